instr_enc_loader: RTL and testbench

Instruction encoder and instruction-memory loader for the RV32I pipeline. Accepts symbolic instruction commands (operation, register indices, immediate) over a valid/ready handshake and packs each into a 32-bit RV32I word. Buffers the words in a small FIFO and writes them sequentially into instruction memory through a second valid/ready port. This is the encode side of the instruction fields that the core's main and ALU decoders consume. Used for boot-time program load and for self-checking benches.

---
 rtl/instr_enc_loader.sv | 140 ++++++++++++++
 tb/tb_instr_enc_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc_loader.sv
// RV32I instruction encoder feeding a small FIFO that streams encoded words into
// instruction memory at sequential, wrapping word addresses.
module instr_enc_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_op,
  input  logic [4:0]                    cmd_rd,
  input  logic [4:0]                    cmd_rs1,
  input  logic [4:0]                    cmd_rs2,
  input  logic [31:0]                   cmd_imm,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [$clog2(IMEM_WORDS)-1:0] wr_addr,
  output logic [31:0]                   wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned AddrW = $clog2(IMEM_WORDS);

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpAddi, OpAndi, OpOri, OpSlti,
    OpLw, OpSw, OpBeq, OpJal
  } op_e;

  logic signed [31:0] imm_s;
  logic               imm12_ok, immb_ok, immj_ok;
  logic [2:0]         funct3;
  logic [31:0]        enc_word;
  logic               enc_ok;

  assign imm_s    = $signed(cmd_imm);
  assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign immb_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !cmd_imm[0];
  assign immj_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !cmd_imm[0];

  // Register and immediate ALU ops share funct3.
  always_comb begin
    funct3 = 3'b000;
    case (op_e'(cmd_op))
      OpAnd, OpAndi: funct3 = 3'b111;
      OpOr, OpOri:   funct3 = 3'b110;
      OpSlt, OpSlti: funct3 = 3'b010;
      default:       funct3 = 3'b000;
    endcase
  end

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (op_e'(cmd_op))
      OpAdd, OpSub, OpAnd, OpOr, OpSlt: begin
        enc_word = {(op_e'(cmd_op) == OpSub) ? 7'b0100000 : 7'b0000000,
                    cmd_rs2, cmd_rs1, funct3, cmd_rd, 7'b0110011};
      end
      OpAddi, OpAndi, OpOri, OpSlti: begin
        enc_word = {cmd_imm[11:0], cmd_rs1, funct3, cmd_rd, 7'b0010011};
        enc_ok   = imm12_ok;
      end
      OpLw: begin
        enc_word = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
        enc_ok   = imm12_ok;
      end
      OpSw: begin
        enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
        enc_ok   = imm12_ok;
      end
      OpBeq: begin
        enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, 3'b000,
                    cmd_imm[4:1], cmd_imm[11], 7'b1100011};
        enc_ok   = immb_ok;
      end
      OpJal: begin
        enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                    cmd_rd, 7'b1101111};
        enc_ok   = immj_ok;
      end
      default: enc_ok = 1'b0;
    endcase
  end

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic [AddrW-1:0] addr_q;
  logic             err_q;
  logic             full, empty, accept, push, pop;

  assign full      = (level_q == LvlW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign cmd_ready = !full && !flush;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && enc_ok;
  // Flush suppresses the pop even though wr_valid may still be high.
  assign pop       = !empty && wr_ready && !flush;

  assign wr_valid   = !empty;
  assign wr_data    = empty ? 32'h0 : mem_q[rptr_q];
  assign wr_addr    = addr_q;
  assign fifo_level = level_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
        addr_q <= addr_q + AddrW'(1);
      end
      if (push && !pop) level_q <= level_q + LvlW'(1);
      else if (!push && pop) level_q <= level_q - LvlW'(1);
      if (accept && !enc_ok) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Bench for instr_enc_loader: queue-based reference model compared every cycle,
// plus directed literal checks of encodings, ordering, backpressure and wrap.
module tb_instr_enc_loader;

  localparam int DEPTH = 4;
  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [31:0] cmd_imm = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  fifo_level;
  logic        err;

  instr_enc_loader #(.FIFO_DEPTH(DEPTH), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .fifo_level(fifo_level), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference encoder built from field positions and plain integer range checks.
  function automatic void enc(input int op, input int rd, input int rs1, input int rs2,
                              input int imm, output bit [31:0] w, output bit ok);
    bit [31:0] u, r, s1, s2, f3;
    u = imm; r = rd; s1 = rs1; s2 = rs2;
    case (op)
      0, 1, 5:  f3 = 0;
      2, 6:     f3 = 7;
      3, 7:     f3 = 6;
      default:  f3 = 2;
    endcase
    ok = 1; w = 0;
    if (op <= 4) begin
      w = ((op == 1) ? 32'h20 << 25 : 0) | s2 << 20 | s1 << 15 | f3 << 12 | r << 7 | 32'h33;
    end else if (op <= 8) begin
      ok = imm >= -2048 && imm <= 2047;
      w = (u & 32'hfff) << 20 | s1 << 15 | f3 << 12 | r << 7 | 32'h13;
    end else if (op == 9) begin
      ok = imm >= -2048 && imm <= 2047;
      w = (u & 32'hfff) << 20 | s1 << 15 | 32'h2 << 12 | r << 7 | 32'h03;
    end else if (op == 10) begin
      ok = imm >= -2048 && imm <= 2047;
      w = ((u >> 5) & 32'h7f) << 25 | s2 << 20 | s1 << 15 | 32'h2 << 12
          | (u & 32'h1f) << 7 | 32'h23;
    end else if (op == 11) begin
      ok = imm >= -4096 && imm <= 4094 && (imm % 2 == 0);
      w = ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3f) << 25 | s2 << 20 | s1 << 15
          | ((u >> 1) & 32'hf) << 8 | ((u >> 11) & 1) << 7 | 32'h63;
    end else if (op == 12) begin
      ok = imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0);
      w = ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3ff) << 21 | ((u >> 11) & 1) << 20
          | ((u >> 12) & 32'hff) << 12 | r << 7 | 32'h6f;
    end else begin
      ok = 0;
    end
  endfunction

  // Model state
  bit [31:0] mq[$];
  int        maddr = 0;
  bit        merr = 0;
  int        cyc = 0;

  // Observed writes
  bit [31:0] lg_data[$];
  int        lg_addr[$];
  int        lg_cyc[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (flush) begin
          mq.delete(); maddr = 0; merr = 0;
        end else begin
          bit        acc, pop, ok;
          bit [31:0] w;
          acc = cmd_valid && (mq.size() < DEPTH);
          pop = (mq.size() > 0) && wr_ready;
          w = 0; ok = 0;
          if (acc) begin
            enc(int'(cmd_op), int'(cmd_rd), int'(cmd_rs1), int'(cmd_rs2), int'(cmd_imm), w, ok);
            if (!ok) merr = 1;
          end
          if (pop) begin
            void'(mq.pop_front());
            maddr = (maddr + 1) % WORDS;
          end
          if (acc && ok) mq.push_back(w);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge rst_n);
      mq.delete(); maddr = 0; merr = 0;
    end
  end

  // Per-cycle comparison against the model, plus write capture.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cmd_ready", 32'(cmd_ready), 32'((mq.size() < DEPTH) && !flush));
        chk("wr_valid", 32'(wr_valid), 32'(mq.size() != 0));
        chk("wr_addr", 32'(wr_addr), 32'(maddr));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("err", 32'(err), 32'(merr));
        if (mq.size() != 0) chk("wr_data", wr_data, mq[0]);
        if (wr_valid && wr_ready && !flush) begin
          lg_data.push_back(wr_data);
          lg_addr.push_back(int'(wr_addr));
          lg_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input int op, input int rd, input int rs1, input int rs2, input int imm);
    cmd_valid = 1'b1;
    cmd_op = op[3:0]; cmd_rd = rd[4:0]; cmd_rs1 = rs1[4:0]; cmd_rs2 = rs2[4:0];
    cmd_imm = imm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("cmd_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  initial begin
    bit [31:0] w;
    bit        ok;
    int        b;

    // Pin the reference encoder to hand-derived words.
    enc(0, 3, 1, 2, 0, w, ok);         chk("pin_add", w, 32'h002081B3);
    enc(1, 5, 6, 7, 0, w, ok);         chk("pin_sub", w, 32'h407302B3);
    enc(5, 1, 0, 0, -1, w, ok);        chk("pin_addi", w, 32'hFFF00093);
    enc(9, 2, 1, 0, 8, w, ok);         chk("pin_lw", w, 32'h0080A103);
    enc(10, 0, 1, 2, 12, w, ok);       chk("pin_sw", w, 32'h0020A623);
    enc(11, 0, 1, 2, -4, w, ok);       chk("pin_beq", w, 32'hFE208EE3);
    enc(12, 1, 0, 0, 8, w, ok);        chk("pin_jal", w, 32'h008000EF);
    enc(7, 4, 5, 0, 127, w, ok);       chk("pin_ori", w, 32'h07F2E213);
    enc(5, 1, 0, 0, 2048, w, ok);      chk("pin_addi_range", 32'(ok), 32'd0);
    enc(11, 0, 1, 2, 3, w, ok);        chk("pin_beq_odd", 32'(ok), 32'd0);

    // Reset values
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // First word latency and SUB
    wr_ready = 1'b1;
    cmd(0, 3, 1, 2, 0);
    cmd_valid = 1'b0;
    chk("add_valid", 32'(wr_valid), 32'd1);
    chk("add_addr", 32'(wr_addr), 32'd0);
    chk("add_data", wr_data, 32'h002081B3);
    tick(1);
    cmd(1, 5, 6, 7, 0);
    cmd_valid = 1'b0;
    chk("sub_addr", 32'(wr_addr), 32'd1);
    chk("sub_data", wr_data, 32'h407302B3);
    tick(2);

    // Back-to-back stream, one write per cycle
    do_flush();
    b = lg_data.size();
    cmd(5, 1, 0, 0, -1);
    cmd(9, 2, 1, 0, 8);
    cmd(10, 0, 1, 2, 12);
    cmd(11, 0, 1, 2, -4);
    cmd(12, 1, 0, 0, 8);
    cmd_valid = 1'b0;
    tick(6);
    chk("stream_count", 32'(lg_data.size() - b), 32'd5);
    if (lg_data.size() - b == 5) begin
      chk("stream_w0", lg_data[b], 32'hFFF00093);
      chk("stream_w1", lg_data[b+1], 32'h0080A103);
      chk("stream_w2", lg_data[b+2], 32'h0020A623);
      chk("stream_w3", lg_data[b+3], 32'hFE208EE3);
      chk("stream_w4", lg_data[b+4], 32'h008000EF);
      for (int k = 0; k < 5; k++) begin
        chk("stream_addr", 32'(lg_addr[b+k]), 32'(k));
        chk("stream_cycle", 32'(lg_cyc[b+k] - lg_cyc[b]), 32'(k));
      end
    end

    // Backpressure: fill, stall, drain
    do_flush();
    wr_ready = 1'b0;
    b = lg_data.size();
    cmd(7, 4, 5, 0, 127);
    cmd(6, 6, 7, 0, -1);
    cmd(8, 8, 9, 0, -2048);
    cmd(2, 10, 11, 12, 0);
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_rd = 5'd13; cmd_rs1 = 5'd14; cmd_rs2 = 5'd15;
    cmd_imm = 0;
    tick(3);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("stall_data", wr_data, 32'h07F2E213);
    chk("stall_addr", 32'(wr_addr), 32'd0);
    wr_ready = 1'b1;
    cmd(4, 13, 14, 15, 0);
    cmd_valid = 1'b0;
    tick(6);
    chk("drain_count", 32'(lg_data.size() - b), 32'd5);
    if (lg_data.size() - b == 5) begin
      chk("drain_first", lg_data[b], 32'h07F2E213);
      chk("drain_last_addr", 32'(lg_addr[b+4]), 32'd4);
    end

    // Illegal and out-of-range commands are consumed and dropped
    b = lg_data.size();
    cmd(13, 1, 2, 3, 0);
    cmd(5, 1, 0, 0, 2048);
    cmd(11, 0, 1, 2, 3);
    cmd_valid = 1'b0;
    tick(2);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_valid", 32'(wr_valid), 32'd0);
    chk("ill_nowrite", 32'(lg_data.size() - b), 32'd0);
    cmd(0, 3, 1, 2, 0);
    cmd_valid = 1'b0;
    chk("ill_next_addr", 32'(wr_addr), 32'd5);
    chk("ill_next_data", wr_data, 32'h002081B3);
    tick(2);
    do_flush();
    chk("flush_err", 32'(err), 32'd0);

    // Range boundaries: edges legal, one past illegal
    b = lg_data.size();
    cmd(5, 1, 0, 0, -2048);
    cmd(5, 1, 0, 0, 2047);
    cmd(11, 0, 1, 2, -4096);
    cmd(11, 0, 1, 2, 4094);
    cmd(12, 1, 0, 0, -1048576);
    cmd(12, 1, 0, 0, 1048574);
    cmd_valid = 1'b0;
    tick(6);
    chk("edge_err", 32'(err), 32'd0);
    chk("edge_count", 32'(lg_data.size() - b), 32'd6);
    cmd(12, 1, 0, 0, 1048576);
    cmd_valid = 1'b0;
    tick(1);
    chk("jal_over_err", 32'(err), 32'd1);
    do_flush();
    cmd(10, 0, 1, 2, -2049);
    cmd_valid = 1'b0;
    tick(1);
    chk("sw_under_err", 32'(err), 32'd1);
    do_flush();

    // Address wrap after 64 writes
    b = lg_data.size();
    for (int i = 0; i < 65; i++) cmd(5, i % 32, 1, 0, i);
    cmd_valid = 1'b0;
    tick(6);
    chk("wrap_count", 32'(lg_data.size() - b), 32'd65);
    if (lg_data.size() - b == 65) begin
      chk("wrap_addr63", 32'(lg_addr[b+63]), 32'd63);
      chk("wrap_addr0", 32'(lg_addr[b+64]), 32'd0);
    end

    // Asynchronous reset with words queued
    wr_ready = 1'b0;
    cmd(0, 1, 2, 3, 0);
    cmd(0, 4, 5, 6, 0);
    cmd(0, 7, 8, 9, 0);
    cmd_valid = 1'b0;
    tick(1);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(wr_valid), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    wr_ready = 1'b1;
    cmd(0, 3, 1, 2, 0);
    cmd_valid = 1'b0;
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_valid", 32'(wr_valid), 32'd1);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
